// File: rtl/cpu_controller.sv
// Moore sequencer for the CPU datapath: one instruction per start strobe s.
// Drives regfile/A/B/C/status load and select strobes plus the w idle flag.
module cpu_controller #(
    parameter int VSEL_W        = 2,
    parameter bit STRICT_DECODE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    output logic              w,
    output logic [2:0]        nsel,
    output logic [VSEL_W-1:0] vsel,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              asel,
    output logic              bsel,
    output logic              loadc,
    output logic              loads,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WIMM   = 3'd2,
        S_GETB   = 3'd3,
        S_EXEC   = 3'd4,
        S_WREG   = 3'd5
    } state_t;

    state_t     r_state;
    logic [2:0] r_opcode;
    logic [1:0] r_op;

    logic w_mov_imm;
    logic w_mov_reg;
    logic w_alu;
    logic w_cmp;
    logic w_mvn;
    logic w_two_src;
    logic w_one_src;
    logic w_legal;

    assign w_mov_imm = (r_opcode == 3'b110) && (r_op == 2'b10);
    assign w_mov_reg = (r_opcode == 3'b110) && (r_op == 2'b00);
    assign w_alu     = (r_opcode == 3'b101);
    assign w_cmp     = w_alu && (r_op == 2'b01);
    assign w_mvn     = w_alu && (r_op == 2'b11);
    assign w_two_src = w_alu && !w_mvn;
    assign w_one_src = w_mov_reg || w_mvn;
    assign w_legal   = w_mov_imm || w_one_src || w_two_src;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_WAIT;
            r_opcode <= 3'b000;
            r_op     <= 2'b00;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (s) begin
                        r_state  <= S_DECODE;
                        r_opcode <= opcode;
                        r_op     <= op;
                    end
                end
                S_DECODE: begin
                    if (w_mov_imm)
                        r_state <= S_WIMM;
                    else if (w_two_src)
                        r_state <= S_GETB;
                    else if (w_one_src)
                        r_state <= S_EXEC;
                    else
                        r_state <= S_WAIT;
                end
                S_WIMM: r_state <= S_WAIT;
                S_GETB: r_state <= S_EXEC;
                S_EXEC: r_state <= w_cmp ? S_WAIT : S_WREG;
                S_WREG: r_state <= S_WAIT;
                default: r_state <= S_WAIT;
            endcase
        end
    end

    // DECODE doubles as the first operand fetch (Rn into A, or Rm into B).
    always_comb begin
        w       = 1'b0;
        nsel    = 3'b000;
        vsel    = '0;
        write   = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_WAIT: w = 1'b1;
            S_DECODE: begin
                if (w_two_src) begin
                    nsel  = 3'b100;
                    loada = 1'b1;
                end else if (w_one_src) begin
                    nsel  = 3'b001;
                    loadb = 1'b1;
                end else if (!w_legal) begin
                    illegal = STRICT_DECODE;
                end
            end
            S_WIMM: begin
                nsel  = 3'b100;
                vsel  = VSEL_W'(1);
                write = 1'b1;
            end
            S_GETB: begin
                nsel  = 3'b001;
                loadb = 1'b1;
            end
            S_EXEC: begin
                asel  = w_one_src;
                loads = w_cmp;
                loadc = !w_cmp;
            end
            S_WREG: begin
                nsel  = 3'b010;
                write = 1'b1;
            end
            default: ;
        endcase
        // An abandoned instruction must not touch any register.
        if (!reset) begin
            write   = 1'b0;
            loada   = 1'b0;
            loadb   = 1'b0;
            loadc   = 1'b0;
            loads   = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench for cpu_controller against a per-instruction
// cycle-sequence reference built from the instruction class.
module tb_cpu_controller;

    logic       clk;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       illegal;

    int n_tests;
    int n_fail;

    logic [13:0] q[$];
    logic [13:0] dut_o;

    cpu_controller dut (
        .clk(clk),
        .reset(reset),
        .s(s),
        .opcode(opcode),
        .op(op),
        .w(w),
        .nsel(nsel),
        .vsel(vsel),
        .write(write),
        .loada(loada),
        .loadb(loadb),
        .asel(asel),
        .bsel(bsel),
        .loadc(loadc),
        .loads(loads),
        .illegal(illegal)
    );

    assign dut_o = {w, nsel, vsel, write, loada, loadb,
                    asel, bsel, loadc, loads, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {w,nsel,vsel,write,loada,loadb,asel,bsel,loadc,loads,illegal}
    localparam logic [13:0] IDLE = 14'b1_000_00_00000000;
    localparam logic [13:0] NONE = 14'b0_000_00_00000000;
    localparam logic [13:0] FA   = 14'b0_100_00_01000000;
    localparam logic [13:0] FB   = 14'b0_001_00_00100000;
    localparam logic [13:0] WIMM = 14'b0_100_01_10000000;
    localparam logic [13:0] EXC  = 14'b0_000_00_00000100;
    localparam logic [13:0] EXAS = 14'b0_000_00_00010100;
    localparam logic [13:0] EXS  = 14'b0_000_00_00000010;
    localparam logic [13:0] WREG = 14'b0_010_00_10000000;
    localparam logic [13:0] ILL  = 14'b0_000_00_00000001;
    localparam logic [13:0] WRGZ = 14'b0_010_00_00000000;

    task automatic check(input string tag, input logic [13:0] got,
                         input logic [13:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b want=%b", tag, got, exp);
        end
    endtask

    // Expected outputs for each cycle after the s-sampling edge,
    // ending with the first idle cycle.
    task automatic build(input logic [2:0] opc, input logic [1:0] o);
        q.delete();
        case ({opc, o})
            5'b110_10: q = '{NONE, WIMM};
            5'b110_00: q = '{FB, EXAS, WREG};
            5'b101_11: q = '{FB, EXAS, WREG};
            5'b101_00: q = '{FA, FB, EXC, WREG};
            5'b101_10: q = '{FA, FB, EXC, WREG};
            5'b101_01: q = '{FA, FB, EXS};
            default:   q = '{ILL};
        endcase
        q.push_back(IDLE);
    endtask

    task automatic run_instr(input string tag, input logic [2:0] opc,
                             input logic [1:0] o, input bit hold);
        logic [13:0] exp;
        opcode = opc;
        op     = o;
        s      = 1'b1;
        build(opc, o);
        for (int k = 0; k < q.size(); k++) begin
            @(posedge clk);
            #1;
            exp = q[k];
            check($sformatf("%s[%0d]", tag, k), dut_o, exp);
            opcode = 3'($urandom_range(0, 7));
            op     = 2'($urandom_range(0, 3));
            if (k == q.size() - 1)
                s = hold;
            else
                s = 1'($urandom_range(0, 1));
        end
    endtask

    logic [2:0] legal_opc[6] = '{3'b110, 3'b110, 3'b101,
                                 3'b101, 3'b101, 3'b101};
    logic [1:0] legal_op[6]  = '{2'b10, 2'b00, 2'b00,
                                 2'b01, 2'b10, 2'b11};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        s       = 1'b1;
        opcode  = 3'b110;
        op      = 2'b10;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset%0d", i), dut_o, IDLE);
        end
        s     = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", dut_o, IDLE);

        run_instr("mov_imm", 3'b110, 2'b10, 1'b0);
        run_instr("add", 3'b101, 2'b00, 1'b0);
        run_instr("cmp", 3'b101, 2'b01, 1'b0);
        run_instr("illegal", 3'b111, 2'b00, 1'b0);
        run_instr("mvn_a", 3'b101, 2'b11, 1'b1);
        run_instr("mvn_b", 3'b101, 2'b11, 1'b0);

        // Reset arriving in WRITE_REG of an ADD
        opcode = 3'b101;
        op     = 2'b00;
        s      = 1'b1;
        build(3'b101, 2'b00);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_add[%0d]", k), dut_o, q[k]);
            s = 1'b0;
        end
        reset = 1'b0;
        s     = 1'b1;
        #1;
        check("abort_write_forced", dut_o, WRGZ);
        @(posedge clk);
        #1;
        check("abort_to_wait", dut_o, IDLE);
        @(posedge clk);
        #1;
        check("reset_beats_s", dut_o, IDLE);
        s     = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_abort", dut_o, IDLE);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] ro;
            logic [1:0] rp;
            int sel;
            sel = $urandom_range(0, 7);
            if (sel < 6) begin
                ro = legal_opc[sel];
                rp = legal_op[sel];
            end else begin
                ro = 3'($urandom_range(0, 7));
                rp = 2'($urandom_range(0, 3));
            end
            run_instr($sformatf("rnd%0d", i), ro, rp,
                      1'($urandom_range(0, 1)));
        end
        s = 1'b0;
        @(posedge clk);
        #1;
        check("final_idle", dut_o, IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
